// File: rtl/exception_ctrl_if.sv
// Exception controller bus: pipeline-side inputs and redirect/flush outputs.
// The master modport is the CPU pipeline side and the slave modport is the controller.
interface exception_ctrl_if;
   logic        irq;
   logic        undef_inst;
   logic        eret;
   logic [31:0] IF_ID_PC;
   logic        hazard_stall;
   logic        branch_flush;
   logic        exc_req;
   logic [31:0] exc_vector;
   logic [31:0] epc;
   logic        epc_we;
   logic        IF_ID_Flush;
   logic        ID_EX_Flush;
   logic        kernel_mode;
   logic [1:0]  cause;

   modport master (
      output irq, undef_inst, eret, IF_ID_PC, hazard_stall, branch_flush,
      input  exc_req, exc_vector, epc, epc_we, IF_ID_Flush, ID_EX_Flush,
             kernel_mode, cause
   );

   modport slave (
      input  irq, undef_inst, eret, IF_ID_PC, hazard_stall, branch_flush,
      output exc_req, exc_vector, epc, epc_we, IF_ID_Flush, ID_EX_Flush,
             kernel_mode, cause
   );
endinterface

// File: rtl/exception_ctrl.sv
// Exception controller for the pipelined MIPS core: takes undefined-instruction
// exceptions and external interrupts at a safe point, redirects the PC, flushes
// IF/ID and ID/EX, and writes the return address into $26.
// Optional macro IRQ_SYNC_EN: when defined, irq passes a 2-flop synchronizer
// before edge detection (irq_pend sets 3 cycles after the rising edge instead of 1).
module exception_ctrl #(
   parameter logic [31:0] IRQ_VECTOR   = 32'h80000004,
   parameter logic [31:0] UNDEF_VECTOR = 32'h80000008
) (
   input logic              clk,
   input logic              reset,
   exception_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PEND   = 2'd1,
      TAKE   = 2'd2,
      KERNEL = 2'd3
   } state_t;

   localparam logic [1:0] CAUSE_NONE  = 2'b00;
   localparam logic [1:0] CAUSE_IRQ   = 2'b01;
   localparam logic [1:0] CAUSE_UNDEF = 2'b10;

   state_t      state_q;
   logic        irqCond;
   logic        irqPrev_q;
   logic        irqEdge;
   logic        irqPend_q;
   logic        irqPend_d;
   logic [31:0] epc_q;
   logic [1:0]  cause_q;
   logic        excReq_q;
   logic        epcWe_q;
   logic        ifIdFlush_q;
   logic        idExFlush_q;
   logic        kernelMode_q;
   logic        safePoint;
   logic        takeUndef;
   logic        takeIrq;
   logic        requestPresent;
   logic        decideState;
   logic [31:0] excVector;

`ifdef IRQ_SYNC_EN
   logic irqSync1_q;
   logic irqSync2_q;

   // Two-flop synchronizer: irq comes from outside the clock domain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irqSync1_q <= 1'b0;
         irqSync2_q <= 1'b0;
      end else begin
         irqSync1_q <= bus.irq;
         irqSync2_q <= irqSync1_q;
      end
   end

   assign irqCond = irqSync2_q;
`else
   assign irqCond = bus.irq;
`endif

   // Remember the previous conditioned irq level so a rising edge counts as one request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irqPrev_q <= 1'b0;
      end else begin
         irqPrev_q <= irqCond;
      end
   end

   // Take decision: undef wins over irq, and nothing is taken while a bubble or
   // redirect is in flight because IF_ID_PC would not be a reliable return point.
   always_comb begin
      irqEdge        = irqCond & ~irqPrev_q;
      safePoint      = ~bus.hazard_stall & ~bus.branch_flush;
      decideState    = (state_q == IDLE) || (state_q == PEND);
      takeUndef      = decideState & safePoint & bus.undef_inst;
      takeIrq        = decideState & safePoint & ~bus.undef_inst & irqPend_q;
      requestPresent = bus.undef_inst | irqPend_q;
      irqPend_d      = irqEdge | (irqPend_q & ~takeIrq);
   end

   // Sticky interrupt request, cleared only when the interrupt is actually taken.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irqPend_q <= 1'b0;
      end else begin
         irqPend_q <= irqPend_d;
      end
   end

   // Main FSM with registered outputs; the pulse outputs are high only in TAKE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         epc_q        <= 32'h0;
         cause_q      <= CAUSE_NONE;
         excReq_q     <= 1'b0;
         epcWe_q      <= 1'b0;
         ifIdFlush_q  <= 1'b0;
         idExFlush_q  <= 1'b0;
         kernelMode_q <= 1'b0;
      end else begin
         excReq_q    <= 1'b0;
         epcWe_q     <= 1'b0;
         ifIdFlush_q <= 1'b0;
         idExFlush_q <= 1'b0;
         case (state_q)
            IDLE, PEND: begin
               kernelMode_q <= 1'b0;
               if (takeUndef) begin
                  state_q     <= TAKE;
                  cause_q     <= CAUSE_UNDEF;
                  epc_q       <= bus.IF_ID_PC + 32'd4;
                  excReq_q    <= 1'b1;
                  epcWe_q     <= 1'b1;
                  ifIdFlush_q <= 1'b1;
                  idExFlush_q <= 1'b1;
               end else if (takeIrq) begin
                  state_q     <= TAKE;
                  cause_q     <= CAUSE_IRQ;
                  epc_q       <= bus.IF_ID_PC;
                  excReq_q    <= 1'b1;
                  epcWe_q     <= 1'b1;
                  ifIdFlush_q <= 1'b1;
                  idExFlush_q <= 1'b1;
               end else if (requestPresent) begin
                  state_q <= PEND;
               end else begin
                  state_q <= IDLE;
               end
            end
            TAKE: begin
               state_q      <= KERNEL;
               kernelMode_q <= 1'b1;
            end
            KERNEL: begin
               if (bus.eret && !bus.hazard_stall) begin
                  state_q      <= IDLE;
                  kernelMode_q <= 1'b0;
                  cause_q      <= CAUSE_NONE;
               end else begin
                  kernelMode_q <= 1'b1;
               end
            end
            default: begin
               state_q      <= IDLE;
               kernelMode_q <= 1'b0;
            end
         endcase
      end
   end

   // Handler address follows the latched cause; no cause means no vector.
   always_comb begin
      excVector = 32'h0;
      case (cause_q)
         CAUSE_IRQ:   excVector = IRQ_VECTOR;
         CAUSE_UNDEF: excVector = UNDEF_VECTOR;
         default:     excVector = 32'h0;
      endcase
   end

   assign bus.exc_req     = excReq_q;
   assign bus.exc_vector  = excVector;
   assign bus.epc         = epc_q;
   assign bus.epc_we      = epcWe_q;
   assign bus.IF_ID_Flush = ifIdFlush_q;
   assign bus.ID_EX_Flush = idExFlush_q;
   assign bus.kernel_mode = kernelMode_q;
   assign bus.cause       = cause_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed testbench for exception_ctrl: undef take, irq with pending hold,
// irq across eret, undef/irq priority, reset during TAKE and irq latency.
module tb_exception_ctrl;

`ifdef IRQ_SYNC_EN
   localparam int IRQ_LAT = 3;
`else
   localparam int IRQ_LAT = 1;
`endif

   logic clk;
   logic reset;
   int   assertCount;
   int   failCount;

   exception_ctrl_if bus ();

   exception_ctrl #(
      .IRQ_VECTOR   (32'h80000004),
      .UNDEF_VECTOR (32'h80000008)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic irq, input logic undefInst, input logic eret,
                                input logic [31:0] pc, input logic hazardStall,
                                input logic branchFlush);
      bus.irq          = irq;
      bus.undef_inst   = undefInst;
      bus.eret         = eret;
      bus.IF_ID_PC     = pc;
      bus.hazard_stall = hazardStall;
      bus.branch_flush = branchFlush;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkQuiet(input string tag, input logic kernel);
      checkOutput({tag, ".exc_req"}, {31'h0, bus.exc_req}, 32'h0);
      checkOutput({tag, ".epc_we"}, {31'h0, bus.epc_we}, 32'h0);
      checkOutput({tag, ".IF_ID_Flush"}, {31'h0, bus.IF_ID_Flush}, 32'h0);
      checkOutput({tag, ".ID_EX_Flush"}, {31'h0, bus.ID_EX_Flush}, 32'h0);
      checkOutput({tag, ".kernel_mode"}, {31'h0, bus.kernel_mode}, {31'h0, kernel});
   endtask

   task automatic checkTake(input string tag, input logic [31:0] vec,
                            input logic [31:0] epcExp, input logic [1:0] causeExp);
      checkOutput({tag, ".exc_req"}, {31'h0, bus.exc_req}, 32'h1);
      checkOutput({tag, ".epc_we"}, {31'h0, bus.epc_we}, 32'h1);
      checkOutput({tag, ".IF_ID_Flush"}, {31'h0, bus.IF_ID_Flush}, 32'h1);
      checkOutput({tag, ".ID_EX_Flush"}, {31'h0, bus.ID_EX_Flush}, 32'h1);
      checkOutput({tag, ".exc_vector"}, bus.exc_vector, vec);
      checkOutput({tag, ".epc"}, bus.epc, epcExp);
      checkOutput({tag, ".cause"}, {30'h0, bus.cause}, {30'h0, causeExp});
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;
      reset       = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      tick();

      // Reset state
      checkQuiet("rst", 1'b0);
      checkOutput("rst.exc_vector", bus.exc_vector, 32'h0);
      checkOutput("rst.epc", bus.epc, 32'h0);
      checkOutput("rst.cause", {30'h0, bus.cause}, 32'h0);
      reset = 1'b0;
      tick();
      checkQuiet("idle", 1'b0);

      // Undefined instruction at a safe point
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h00400010, 1'b0, 1'b0);
      tick();
      checkTake("undef.take", 32'h80000008, 32'h00400014, 2'b10);
      checkOutput("undef.take.kernel", {31'h0, bus.kernel_mode}, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h00400010, 1'b0, 1'b0);
      tick();
      checkQuiet("undef.kernel", 1'b1);
      checkOutput("undef.kernel.cause", {30'h0, bus.cause}, 32'h2);
      checkOutput("undef.kernel.epc", bus.epc, 32'h00400014);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h00400018, 1'b0, 1'b0);
      tick();
      checkQuiet("undef.ignored", 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h00400018, 1'b1, 1'b0);
      tick();
      checkQuiet("eret.stalled", 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h00400018, 1'b0, 1'b0);
      tick();
      checkQuiet("eret.idle", 1'b0);
      checkOutput("eret.cause", {30'h0, bus.cause}, 32'h0);
      checkOutput("eret.exc_vector", bus.exc_vector, 32'h0);
      checkOutput("eret.epc_hold", bus.epc, 32'h00400014);

      // Interrupt held off by a redirect, then taken at the safe point
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h00400020, 1'b0, 1'b1);
      for (int i = 0; i < IRQ_LAT + 2; i++) begin
         tick();
         checkQuiet("irq.held", 1'b0);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h00400020, 1'b0, 1'b0);
      tick();
      checkTake("irq.take", 32'h80000004, 32'h00400020, 2'b01);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h00400024, 1'b0, 1'b0);
      tick();
      checkQuiet("irq.kernel", 1'b1);
      for (int i = 0; i < 4; i++) tick();

      // New irq edge in KERNEL is taken only after eret
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h00400024, 1'b0, 1'b0);
      for (int i = 0; i < IRQ_LAT + 1; i++) begin
         tick();
         checkQuiet("kirq.nonest", 1'b1);
      end
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h00400024, 1'b0, 1'b0);
      tick();
      checkQuiet("kirq.idle", 1'b0);
      checkOutput("kirq.idle.cause", {30'h0, bus.cause}, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h00400100, 1'b0, 1'b0);
      tick();
      checkTake("kirq.take", 32'h80000004, 32'h00400100, 2'b01);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h00400104, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 4; i++) tick();
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h00400104, 1'b0, 1'b0);
      tick();
      checkQuiet("kirq.eret", 1'b0);

      // Undef wins over a pending irq; irq taken after eret
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h00400104, 1'b1, 1'b0);
      for (int i = 0; i < IRQ_LAT + 1; i++) begin
         tick();
         checkQuiet("prio.stall", 1'b0);
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h00400200, 1'b0, 1'b0);
      tick();
      checkTake("prio.undef", 32'h80000008, 32'h00400204, 2'b10);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h00400208, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 4; i++) begin
         tick();
         checkQuiet("prio.kernel", 1'b1);
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h00400208, 1'b0, 1'b0);
      tick();
      checkQuiet("prio.eret", 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h00400300, 1'b0, 1'b0);
      tick();
      checkTake("prio.irq", 32'h80000004, 32'h00400300, 2'b01);
      tick();
      checkQuiet("prio.irq.kernel", 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h00400304, 1'b0, 1'b0);
      tick();
      checkQuiet("prio.irq.eret", 1'b0);

      // irq latency with no stalls, then reset during TAKE
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h00400400, 1'b0, 1'b0);
      for (int i = 0; i < IRQ_LAT; i++) begin
         tick();
         checkQuiet("lat.wait", 1'b0);
      end
      tick();
      checkTake("lat.take", 32'h80000004, 32'h00400400, 2'b01);
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h00400400, 1'b0, 1'b0);
      #1;
      checkQuiet("rtake", 1'b0);
      checkOutput("rtake.exc_vector", bus.exc_vector, 32'h0);
      checkOutput("rtake.epc", bus.epc, 32'h0);
      checkOutput("rtake.cause", {30'h0, bus.cause}, 32'h0);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         checkQuiet("rtake.after", 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
